// File: rtl/rf_alu_dm_pkg.sv
// rtl/rf_alu_dm_pkg.sv - shared ALU codes, stage control type and XZR index for the EX/MEM/WB datapath
package rf_alu_dm_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // The highest register index is the hard-wired zero register.
  function automatic int xzr_idx(input int nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - combinational ALU with result and zero flag
module pipe_alu
  import rf_alu_dm_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      ALU_NOR:   result = ~(a | b);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rf_alu_dm_pipe.sv
// rtl/rf_alu_dm_pipe.sv - 3-stage EX/MEM/WB datapath: register file, forwarding, load-use stall, data memory
module rf_alu_dm_pipe
  import rf_alu_dm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NREG     = 32,
  parameter int DM_DEPTH = 128,
  parameter int SE_W     = 9
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [$clog2(NREG)-1:0]  Read1,
  input  logic [$clog2(NREG)-1:0]  Read2,
  input  logic [$clog2(NREG)-1:0]  WriteReg,
  input  logic                     RegWrite,
  input  logic [3:0]               ALUoperation,
  input  logic                     ALUSrc,
  input  logic [SE_W-1:0]          Imm,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  output logic                     Zero,
  output logic                     WbValid,
  output logic [$clog2(NREG)-1:0]  WbReg,
  output logic [DATA_W-1:0]        WbData
);

  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(DM_DEPTH);
  localparam logic [RW-1:0] XZR = RW'(xzr_idx(NREG));

  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] dm [DM_DEPTH];

  // EX stage
  logic            ex_valid;
  logic [RW-1:0]   ex_r1, ex_r2, ex_wr;
  ctrl_t           ex_ctrl;
  logic [3:0]      ex_op;
  logic            ex_alusrc;
  logic [SE_W-1:0] ex_imm;

  // MEM stage
  logic              mem_valid;
  logic [DATA_W-1:0] mem_result, mem_sdata;
  logic [RW-1:0]     mem_wr;
  ctrl_t             mem_ctrl;

  logic              accept, ex_load_hz, mem_load, mem_fwd_ok;
  logic [DATA_W-1:0] op_a, op_b, alu_b, alu_result, imm_se;
  logic              alu_zero;
  logic [AW-1:0]     mem_idx;

  // Store wins when both memory controls are set, so only MemRead-without-MemWrite is a load.
  assign ex_load_hz = ex_valid && ex_ctrl.mem_read && !ex_ctrl.mem_write &&
                      ex_ctrl.reg_write && (ex_wr != XZR);
  assign InReady    = !(ex_load_hz && ((ex_wr == Read1) ||
                                       ((ex_wr == Read2) && (!ALUSrc || MemWrite))));
  assign accept     = InValid && InReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid <= accept;
    end
    if (accept) begin
      ex_r1     <= Read1;
      ex_r2     <= Read2;
      ex_wr     <= WriteReg;
      ex_ctrl   <= '{reg_write: RegWrite, mem_read: MemRead, mem_write: MemWrite};
      ex_op     <= ALUoperation;
      ex_alusrc <= ALUSrc;
      ex_imm    <= Imm;
    end
  end

  assign mem_load   = mem_ctrl.mem_read && !mem_ctrl.mem_write;
  assign mem_fwd_ok = mem_valid && mem_ctrl.reg_write && !mem_load && (mem_wr != XZR);

  // Operand select: XZR, then MEM result, then WB data, then register file.
  always_comb begin
    op_a = rf[ex_r1];
    if (ex_r1 == XZR)                         op_a = '0;
    else if (mem_fwd_ok && mem_wr == ex_r1)   op_a = mem_result;
    else if (WbValid && WbReg == ex_r1)       op_a = WbData;
  end

  always_comb begin
    op_b = rf[ex_r2];
    if (ex_r2 == XZR)                         op_b = '0;
    else if (mem_fwd_ok && mem_wr == ex_r2)   op_b = mem_result;
    else if (WbValid && WbReg == ex_r2)       op_b = WbData;
  end

  assign imm_se = {{(DATA_W-SE_W){ex_imm[SE_W-1]}}, ex_imm};
  assign alu_b  = ex_alusrc ? imm_se : op_b;

  pipe_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (op_a),
    .b      (alu_b),
    .op     (ex_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mem_valid <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      mem_valid <= ex_valid;
      if (ex_valid) begin
        Zero <= alu_zero;
      end
    end
    if (ex_valid) begin
      mem_result <= alu_result;
      mem_sdata  <= op_b;
      mem_wr     <= ex_wr;
      mem_ctrl   <= ex_ctrl;
    end
  end

  // Byte offset bits are dropped and high bits wrap the word index.
  assign mem_idx = mem_result[AW+2:3];

  always_ff @(posedge Clock) begin
    if (!Reset && mem_valid && mem_ctrl.mem_write) begin
      dm[mem_idx] <= mem_sdata;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      WbValid <= 1'b0;
      WbReg   <= '0;
      WbData  <= '0;
    end else begin
      WbValid <= mem_valid && mem_ctrl.reg_write && (mem_wr != XZR);
      if (mem_valid) begin
        WbReg  <= mem_wr;
        WbData <= mem_load ? dm[mem_idx] : mem_result;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (WbValid) begin
      rf[WbReg] <= WbData;
    end
  end

endmodule

// File: tb/tb_rf_alu_dm_pipe.sv
// tb/tb_rf_alu_dm_pipe.sv - scoreboard bench for rf_alu_dm_pipe against a sequential architectural model
module tb_rf_alu_dm_pipe;
  import rf_alu_dm_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  Read1 = '0, Read2 = '0, WriteReg = '0;
  logic        RegWrite = 1'b0;
  logic [3:0]  ALUoperation = '0;
  logic        ALUSrc = 1'b0;
  logic [8:0]  Imm = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic        Zero, WbValid;
  logic [4:0]  WbReg;
  logic [63:0] WbData;

  rf_alu_dm_pipe dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .ALUoperation(ALUoperation), .ALUSrc(ALUSrc), .Imm(Imm),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Zero(Zero), .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          cyc;
    logic        wbv;
    logic [4:0]  wr;
    logic [63:0] data;
  } wb_exp_t;

  typedef struct {
    int   cyc;
    logic z;
  } z_exp_t;

  wb_exp_t     wb_q[$];
  z_exp_t      z_q[$];
  logic [63:0] regs_m [32];
  logic [63:0] dm_m [128];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          stalls = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // WB results are due two edges after the accept edge; Zero one edge after.
  always @(negedge Clock) begin
    if (cyc > 0) begin
      if (wb_q.size() > 0 && wb_q[0].cyc + 2 <= cyc) begin
        wb_exp_t e;
        e = wb_q.pop_front();
        check("wb_valid", WbValid, e.wbv);
        if (e.wbv) begin
          check("wb_reg", WbReg, e.wr);
          check("wb_data", WbData, e.data);
        end
      end else begin
        check("wb_idle", WbValid, 1'b0);
      end
      if (z_q.size() > 0 && z_q[0].cyc + 1 <= cyc) begin
        z_exp_t z;
        z = z_q.pop_front();
        check("zero", Zero, z.z);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] wr, input logic rw, input logic src, input int imm,
                       input logic mr, input logic mw);
    logic [63:0] a, b, bb, res, wd;
    logic [8:0]  im9;
    wb_exp_t     e;
    z_exp_t      z;
    int          guard;
    im9 = imm[8:0];
    @(negedge Clock);
    InValid = 1'b1; Read1 = r1; Read2 = r2; WriteReg = wr; RegWrite = rw;
    ALUoperation = op; ALUSrc = src; Imm = im9; MemRead = mr; MemWrite = mw;
    #1;
    guard = 0;
    while (!InReady && guard < 20) begin
      stalls++;
      guard++;
      @(negedge Clock);
      #1;
    end
    if (!InReady) check("ready_timeout", InReady, 1'b1);
    a  = (r1 == 5'd31) ? 64'd0 : regs_m[r1];
    b  = (r2 == 5'd31) ? 64'd0 : regs_m[r2];
    bb = src ? {{55{im9[8]}}, im9} : b;
    case (op)
      ALU_AND:   res = a & bb;
      ALU_OR:    res = a | bb;
      ALU_ADD:   res = a + bb;
      ALU_SUB:   res = a - bb;
      ALU_PASSB: res = bb;
      ALU_NOR:   res = ~(a | bb);
      default:   res = 64'd0;
    endcase
    if (mw) dm_m[res[9:3]] = b;
    wd = (mr && !mw) ? dm_m[res[9:3]] : res;
    if (rw && wr != 5'd31) regs_m[wr] = wd;
    e.cyc = cyc + 1; e.wbv = rw && (wr != 5'd31); e.wr = wr; e.data = wd;
    z.cyc = cyc + 1; z.z = (res == 64'd0);
    wb_q.push_back(e);
    z_q.push_back(z);
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    MemWrite = 1'b0;
    MemRead = 1'b0;
    RegWrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs_m[i] = '0;
    for (int i = 0; i < 128; i++) dm_m[i] = '0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("rst_inready", InReady, 1'b1);
    check("rst_zero", Zero, 1'b0);
    check("rst_wbvalid", WbValid, 1'b0);
    check("rst_wbreg", WbReg, 5'd0);
    check("rst_wbdata", WbData, 64'd0);

    issue(ALU_ADD, 5'd31, 5'd0, 5'd1, 1, 1, 5, 0, 0);
    issue(ALU_ADD, 5'd1, 5'd0, 5'd2, 1, 1, 3, 0, 0);
    issue(ALU_SUB, 5'd2, 5'd2, 5'd3, 1, 0, 0, 0, 0);

    issue(ALU_ADD, 5'd31, 5'd0, 5'd8, 1, 1, -3, 0, 0);
    issue(ALU_AND, 5'd8, 5'd2, 5'd9, 1, 0, 0, 0, 0);
    issue(ALU_OR, 5'd8, 5'd1, 5'd10, 1, 0, 0, 0, 0);
    issue(ALU_NOR, 5'd1, 5'd2, 5'd11, 1, 0, 0, 0, 0);
    issue(ALU_PASSB, 5'd1, 5'd0, 5'd12, 1, 1, -100, 0, 0);
    issue(4'b1010, 5'd1, 5'd2, 5'd13, 1, 0, 0, 0, 0);

    issue(ALU_ADD, 5'd31, 5'd0, 5'd14, 1, 1, 1, 0, 0);
    issue(ALU_ADD, 5'd31, 5'd0, 5'd14, 1, 1, 2, 0, 0);
    issue(ALU_ADD, 5'd14, 5'd0, 5'd15, 1, 1, 0, 0, 0);
    issue(ALU_ADD, 5'd1, 5'd0, 5'd16, 1, 1, 1, 0, 0);
    issue(ALU_ADD, 5'd31, 5'd0, 5'd17, 1, 1, 0, 0, 0);
    issue(ALU_ADD, 5'd16, 5'd16, 5'd18, 1, 0, 0, 0, 0);

    stalls = 0;
    issue(ALU_ADD, 5'd31, 5'd1, 5'd0, 0, 1, 16, 0, 1);
    issue(ALU_ADD, 5'd31, 5'd0, 5'd4, 1, 1, 16, 1, 0);
    issue(ALU_ADD, 5'd4, 5'd4, 5'd5, 1, 0, 0, 0, 0);
    check("load_use_stalls", stalls, 1);

    issue(ALU_ADD, 5'd31, 5'd0, 5'd31, 1, 1, 7, 0, 0);
    issue(ALU_ADD, 5'd31, 5'd0, 5'd19, 1, 1, 0, 0, 0);

    issue(ALU_ADD, 5'd31, 5'd0, 5'd6, 1, 1, 129, 0, 0);
    issue(ALU_ADD, 5'd6, 5'd6, 5'd6, 1, 0, 0, 0, 0);
    issue(ALU_ADD, 5'd6, 5'd6, 5'd6, 1, 0, 0, 0, 0);
    issue(ALU_ADD, 5'd6, 5'd6, 5'd6, 1, 0, 0, 0, 0);
    issue(ALU_ADD, 5'd6, 5'd2, 5'd0, 0, 1, 0, 0, 1);
    issue(ALU_ADD, 5'd31, 5'd0, 5'd7, 1, 1, 8, 1, 0);

    issue(ALU_ADD, 5'd31, 5'd1, 5'd20, 1, 1, 24, 1, 1);
    issue(ALU_ADD, 5'd31, 5'd0, 5'd21, 1, 1, 24, 1, 0);

    repeat (5) @(negedge Clock);
    InValid = 1'b1; Read1 = 5'd31; Read2 = 5'd2; WriteReg = 5'd0; RegWrite = 1'b0;
    ALUoperation = ALU_ADD; ALUSrc = 1'b1; Imm = 9'd16; MemRead = 1'b0; MemWrite = 1'b1;
    #1 check("rst_store_ready", InReady, 1'b1);
    @(posedge Clock);
    #1;
    InValid = 1'b0; MemWrite = 1'b0; Reset = 1'b1;
    wb_q.delete();
    z_q.delete();
    for (int i = 0; i < 32; i++) regs_m[i] = '0;
    @(posedge Clock);
    #1 Reset = 1'b0;
    check("post_rst_inready", InReady, 1'b1);
    @(negedge Clock);
    check("post_rst_inready2", InReady, 1'b1);
    check("post_rst_wbvalid", WbValid, 1'b0);
    check("post_rst_wbdata", WbData, 64'd0);
    check("post_rst_zero", Zero, 1'b0);

    for (int i = 0; i < 31; i++) begin
      issue(ALU_ADD, 5'(i), 5'd31, 5'(i), 1, 1, 0, 0, 0);
    end
    issue(ALU_ADD, 5'd31, 5'd0, 5'd22, 1, 1, 16, 1, 0);

    repeat (6) @(negedge Clock);
    check("wb_q_drained", wb_q.size(), 0);
    check("z_q_drained", z_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
